// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  localparam int MAX_DATA_WIDTH = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic                      parity_err;
    logic                      frame_err;
    logic [MAX_DATA_WIDTH-1:0] data;
  } rx_word_t;

  function automatic rx_word_t make_word(input logic pe, input logic fe,
                                         input logic [MAX_DATA_WIDTH-1:0] d);
    rx_word_t w;
    w.parity_err = pe;
    w.frame_err  = fe;
    w.data       = d;
    return w;
  endfunction

  function automatic int div_calc(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

  // Encoding 3 is reserved and behaves like no parity.
  function automatic parity_mode_t decode_parity(input logic [1:0] m);
    case (m)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received words; a push while full is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote, runtime parity and 1/2 stop bits.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH output FIFO; otherwise a single holding register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_in,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  break_det
);

  localparam int DIV = div_calc(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_WIDTH);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [OCW-1:0] OS_LAST  = OCW'(OVERSAMPLE - 1);
  localparam logic [OCW-1:0] OS_V0    = OCW'(M - 1);
  localparam logic [OCW-1:0] OS_V1    = OCW'(M);
  localparam logic [OCW-1:0] OS_V2    = OCW'(M + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  logic                  rx_meta, rx_s;
  rx_state_t             state, state_n;
  logic [DCW-1:0]        div_cnt;
  logic [OCW-1:0]        os_cnt;
  logic [1:0]            votes;
  logic                  tick, vote, vote_now, bit_end;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BCW-1:0]        bit_idx;
  logic                  stop_idx, last_stop, is_break;
  parity_mode_t          pmode;
  logic                  two_stop_l, par_bit, par_err_r, frm_err_r;
  logic                  push, brk, pop, buf_full;
  rx_word_t              push_word, head;
  logic                  unused_head;

  assign tick      = (div_cnt == DIV_LAST);
  assign vote_now  = tick && (os_cnt == OS_V2);
  assign bit_end   = tick && (os_cnt == OS_LAST);
  assign vote      = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);
  assign last_stop = (stop_idx == two_stop_l);
  assign is_break  = (shreg == '0) && (pmode == PAR_NONE || !par_bit) && !vote && !stop_idx;
  assign push_word = make_word(par_err_r, frm_err_r | ~vote, MAX_DATA_WIDTH'(shreg));

  // Leaving for IDLE at the last stop-bit vote lets the next start edge be seen mid stop bit.
  always_comb begin
    state_n = state;
    push    = 1'b0;
    brk     = 1'b0;
    case (state)
      IDLE:     if (!rx_s) state_n = START;
      START: begin
        if (vote_now && vote) state_n = IDLE;
        else if (bit_end)     state_n = DATA;
      end
      DATA:     if (bit_end && bit_idx == BIT_LAST)
                  state_n = (pmode == PAR_NONE) ? STOP : PARITY;
      PARITY:   if (bit_end) state_n = STOP;
      STOP: begin
        if (vote_now) begin
          if (is_break) begin
            brk     = 1'b1;
            state_n = BRK_WAIT;
          end else if (last_stop) begin
            push    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      BRK_WAIT: if (rx_s) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      div_cnt    <= '0;
      os_cnt     <= '0;
      votes      <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      pmode      <= PAR_NONE;
      two_stop_l <= 1'b0;
      par_bit    <= 1'b0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_meta   <= uart_in;
      rx_s      <= rx_meta;
      state     <= state_n;
      break_det <= brk;
      if (state == IDLE || state == BRK_WAIT) begin
        div_cnt   <= '0;
        os_cnt    <= '0;
        bit_idx   <= '0;
        stop_idx  <= 1'b0;
        par_bit   <= 1'b0;
        par_err_r <= 1'b0;
        frm_err_r <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        if (tick && os_cnt == OS_V0) votes[0] <= rx_s;
        if (tick && os_cnt == OS_V1) votes[1] <= rx_s;
        // Line settings are frozen once the start bit is confirmed.
        if (vote_now) begin
          case (state)
            START: if (!vote) begin
              pmode      <= decode_parity(parity_mode);
              two_stop_l <= two_stop;
            end
            DATA:   shreg <= {vote, shreg[DATA_WIDTH-1:1]};
            PARITY: begin
              par_bit   <= vote;
              par_err_r <= ((^shreg) ^ vote) != (pmode == PAR_ODD);
            end
            STOP:   if (!vote) frm_err_r <= 1'b1;
            default: ;
          endcase
        end
        if (bit_end) begin
          case (state)
            DATA:    bit_idx  <= bit_idx + 1'b1;
            STOP:    stop_idx <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign pop = valid && ready;

`ifdef UART_RX_FIFO_EN
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      unused_count;

  uart_rx_fifo #(
    .WIDTH ($bits(rx_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .full  (buf_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign valid        = !fifo_empty;
  assign unused_count = ^fifo_count;

  always_ff @(posedge clk) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= push && buf_full && !pop;
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic hold_valid;

  assign buf_full = hold_valid;
  assign valid    = hold_valid;

  // A push into a full register succeeds only when the stored word leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      head       <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push && buf_full && !pop;
      if (push && (!buf_full || pop)) begin
        head       <= push_word;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

  assign data        = head.data[DATA_WIDTH-1:0];
  assign parity_err  = head.parity_err;
  assign frame_err   = head.frame_err;
  assign unused_head = ^head;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os; the clock is scaled so one bit lasts 48 clk and the run stays short.
module tb_uart_rx_os;

  localparam int DATA_WIDTH = 8;
  localparam int BAUD_RATE  = 115200;
  localparam int OVERSAMPLE = 16;
  localparam int CLK_FREQ   = BAUD_RATE * OVERSAMPLE * 3;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_FIFO_EN
  localparam int KEEP = 4;
`else
  localparam int KEEP = 1;
`endif

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk, rst, uart_in, two_stop, ready, valid;
  logic [1:0] parity_mode;
  logic [7:0] data;
  logic       parity_err, frame_err, overrun, break_det;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks, errors, pops, ovr_cnt, brk_cnt;
  bit   rand_ready;
  logic ready_force;

  uart_rx_os #(
    .DATA_WIDTH (DATA_WIDTH),
    .BAUD_RATE  (BAUD_RATE),
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_in     (uart_in),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .break_det   (break_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference parity rule: even mode wants an even count of ones over data+parity, odd mode an odd count.
  function automatic logic ref_parity_err(input logic [7:0] d, input logic [1:0] mode, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (mode == 2'd1) return (ones % 2) != 0;
    if (mode == 2'd2) return (ones % 2) != 1;
    return 1'b0;
  endfunction

  task automatic driveBit(input logic b);
    uart_in = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                               input logic ts, input logic stop_val, input int idle_bits,
                               input bit keep);
    exp_t e;
    bit   has_par;
    has_par = (mode == 2'd1) || (mode == 2'd2);
    if (keep) begin
      e.d  = d;
      e.pe = ref_parity_err(d, mode, pbit);
      e.fe = !stop_val;
      exp_q.push_back(e);
    end
    parity_mode = mode;
    two_stop    = ts;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    if (has_par) driveBit(pbit);
    driveBit(stop_val);
    if (ts) driveBit(1'b1);
    for (int i = 0; i < idle_bits; i++) driveBit(1'b1);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20 * BIT_CLKS) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput({"pending_words_", name}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: every accepted word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun)   ovr_cnt++;
      if (break_det) brk_cnt++;
      if (valid && ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got data %0h, expected no word", data);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("data", 32'(data), 32'(mon_e.d));
          checkOutput("parity_err", 32'(parity_err), 32'(mon_e.pe));
          checkOutput("frame_err", 32'(frame_err), 32'(mon_e.fe));
        end
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p, b, o;
    logic [7:0] d;
    rst = 1'b1; uart_in = 1'b1; parity_mode = 2'd0; two_stop = 1'b0;
    rand_ready = 1'b0; ready_force = 1'b0;
    checks = 0; errors = 0; pops = 0; ovr_cnt = 0; brk_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_data", 32'(data), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_break_det", 32'(break_det), 32'd0);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    $display("[TB] random frames");
    rand_ready = 1'b1;
    applyStimulus(8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    applyStimulus(8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      applyStimulus(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2), 1'b1);
    end
    waitDrain("random");
    checkOutput("overrun_during_random", 32'(ovr_cnt), 32'd0);

    $display("[TB] parity and framing");
    applyStimulus(8'h5A, 2'd1, 1'b1, 1'b0, 1'b1, 2, 1'b1);
    applyStimulus(8'h5A, 2'd2, 1'b1, 1'b0, 1'b1, 2, 1'b1);
    applyStimulus(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    applyStimulus(8'h3D, 2'd0, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    waitDrain("parity_frame");

    $display("[TB] false start and break");
    p = pops;
    uart_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    uart_in = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    checkOutput("false_start_words", 32'(pops - p), 32'd0);
    b = brk_cnt;
    parity_mode = 2'd0;
    uart_in = 1'b0;
    repeat (12 * BIT_CLKS) @(posedge clk);
    #1;
    uart_in = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    checkOutput("break_pulses", 32'(brk_cnt - b), 32'd1);
    checkOutput("break_words", 32'(pops - p), 32'd0);

    $display("[TB] overrun");
    rand_ready = 1'b0;
    ready_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = ovr_cnt;
    for (int i = 0; i <= KEEP; i++)
      applyStimulus(8'(8'h11 * (i + 1)), 2'd0, 1'b0, 1'b0, 1'b1, 0, i < KEEP);
    driveBit(1'b1);
    checkOutput("overrun_pulses", 32'(ovr_cnt - o), 32'd1);
    checkOutput("valid_while_full", 32'(valid), 32'd1);
    ready_force = 1'b1;
    waitDrain("overrun_drain");
    rand_ready = 1'b1;

    $display("[TB] reset mid-frame");
    d = 8'h77;
    p = pops;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(d[i]);
    uart_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    driveBit(1'b1);
    driveBit(1'b1);
    applyStimulus(8'h88, 2'd0, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    waitDrain("reset_recovery");
    checkOutput("reset_recovery_words", 32'(pops - p), 32'd1);

    checkOutput("total_overruns", 32'(ovr_cnt), 32'd1);
    checkOutput("total_breaks", 32'(brk_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
